// File: rtl/led_arbiter.sv
// led_arbiter
//   Shares the board LED bank between three requesters:
//     0 = JTAG host-write path (already in clk domain)
//     1 = heartbeat blinker
//     2 = switch/debug override
//   Round-robin arbitration with a req/ack handshake. After each grant the
//   LEDs are held for HOLD_CYCLES cycles before the next arbitration, so the
//   bank cannot flicker between owners.
//
// Optional feature macro: LED_ARB_PRIO_EN
//   When defined, requester 0 wins whenever its req is set and grants to it
//   leave the round-robin pointer untouched; otherwise all requesters are equal.
//
// Ports
//   clk     in   system clock, rising edge
//   reset_  in   synchronous active-low reset
//   req     in   [2:0] request per requester
//   data0-2 in   [LED_W-1:0] LED value offered by each requester
//   ack     out  [2:0] one-cycle pulse on the granted requester's bit
//   leds    out  [LED_W-1:0] registered LED drive
//   owner   out  [1:0] last grantee, 2'd3 = none since reset
//   busy    out  high while holding after a grant
module led_arbiter #(
    parameter int               LED_W       = 3,
    parameter int               HOLD_CYCLES = 1000,
    parameter logic [LED_W-1:0] LED_RESET   = '0
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic [2:0]       req,
    input  logic [LED_W-1:0] data0,
    input  logic [LED_W-1:0] data1,
    input  logic [LED_W-1:0] data2,
    output logic [2:0]       ack,
    output logic [LED_W-1:0] leds,
    output logic [1:0]       owner,
    output logic             busy
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       rr_ptr, rr_ptr_n;
    logic [LED_W-1:0] leds_n;
    logic [1:0]       owner_n;
    logic [2:0]       ack_n;

    logic [1:0]       sel;
    logic             found;
    logic [1:0]       cand [3];
    logic [LED_W-1:0] sel_data;

    // mod-3 increment; encoding 3 never appears on the pointer
    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Scan order starting at rr_ptr
    always_comb begin
        cand[0] = rr_ptr;
        cand[1] = inc3(rr_ptr);
        cand[2] = inc3(inc3(rr_ptr));
    end

    always_comb begin
        sel   = 2'd0;
        found = 1'b0;
`ifdef LED_ARB_PRIO_EN
        if (req[0]) begin
            sel   = 2'd0;
            found = 1'b1;
        end
`endif
        for (int k = 0; k < 3; k++) begin
            if (!found && req[cand[k]]) begin
                sel   = cand[k];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        case (sel)
            2'd0:    sel_data = data0;
            2'd1:    sel_data = data1;
            default: sel_data = data2;
        endcase
    end

    // Next-state and output logic
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        rr_ptr_n = rr_ptr;
        leds_n   = leds;
        owner_n  = owner;
        ack_n    = 3'b000;
        case (state)
            IDLE: begin
                if (found) begin
                    leds_n   = sel_data;
                    ack_n    = 3'b001 << sel;
                    owner_n  = sel;
                    cnt_n    = CNT_W'(HOLD_CYCLES - 1);
                    state_n  = HOLD;
`ifdef LED_ARB_PRIO_EN
                    // the priority requester does not consume a round-robin turn
                    if (sel != 2'd0)
                        rr_ptr_n = inc3(sel);
`else
                    rr_ptr_n = inc3(sel);
`endif
                end
            end
            HOLD: begin
                // saturating countdown; leave once it has reached zero
                if (cnt != '0)
                    cnt_n = cnt - 1'b1;
                else
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state  <= IDLE;
            cnt    <= '0;
            rr_ptr <= 2'd0;
            leds   <= LED_RESET;
            owner  <= 2'd3;
            ack    <= 3'b000;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            rr_ptr <= rr_ptr_n;
            leds   <= leds_n;
            owner  <= owner_n;
            ack    <= ack_n;
        end
    end

    assign busy = (state == HOLD);

endmodule

// File: tb/tb_led_arbiter.sv
// Testbench for led_arbiter (HOLD_CYCLES=4, LED_W=3, LED_RESET=0).
// Directed steps from the test plan followed by a random phase, all checked
// against a cycle-level model that tracks remaining hold cycles and the
// round-robin pointer as plain integers.
module tb_led_arbiter;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       reset_ = 1'b0;
    logic [2:0] req = 3'b000;
    logic [2:0] data0 = '0, data1 = '0, data2 = '0;
    logic [2:0] ack;
    logic [2:0] leds;
    logic [1:0] owner;
    logic       busy;

    led_arbiter #(.LED_W(3), .HOLD_CYCLES(HOLD), .LED_RESET(3'b000)) dut (
        .clk(clk), .reset_(reset_), .req(req),
        .data0(data0), .data1(data1), .data2(data2),
        .ack(ack), .leds(leds), .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // reference model state
    int         m_ptr = 0;
    int         m_hold_left = 0;
    logic [2:0] m_leds = 3'b000;
    logic [1:0] m_owner = 2'd3;
    logic [2:0] m_ack = 3'b000;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic [2:0] r,
                              input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2);
        int sel;
        logic [2:0] d [3];
        d[0] = a0; d[1] = a1; d[2] = a2;
        if (!rst) begin
            m_leds = 3'b000; m_ack = 3'b000; m_owner = 2'd3;
            m_ptr = 0; m_hold_left = 0;
        end else begin
            m_ack = 3'b000;
            if (m_hold_left > 0) begin
                m_hold_left--;
            end else if (r != 3'b000) begin
                sel = -1;
`ifdef LED_ARB_PRIO_EN
                if (r[0]) sel = 0;
`endif
                for (int k = 0; k < 3; k++)
                    if (sel < 0 && r[(m_ptr + k) % 3]) sel = (m_ptr + k) % 3;
                m_leds  = d[sel];
                m_ack   = 3'(1 << sel);
                m_owner = 2'(sel);
`ifdef LED_ARB_PRIO_EN
                if (sel != 0) m_ptr = (sel + 1) % 3;
`else
                m_ptr = (sel + 1) % 3;
`endif
                m_hold_left = HOLD;
            end
        end
    endtask

    task automatic step(input logic rst, input logic [2:0] r,
                        input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2);
        @(negedge clk);
        reset_ = rst; req = r; data0 = a0; data1 = a1; data2 = a2;
        @(posedge clk);
        model_edge(rst, r, a0, a1, a2);
        cyc++;
        #1;
        check("ack",   {1'b0, ack},   {1'b0, m_ack});
        check("leds",  {1'b0, leds},  {1'b0, m_leds});
        check("owner", {2'b0, owner}, {2'b0, m_owner});
        check("busy",  {3'b0, busy},  {3'b0, logic'(m_hold_left > 0)});
    endtask

    int first_ack_cyc;
    int second_ack_cyc;

    initial begin
        // reset with all requests high
        step(1'b0, 3'b111, 3'b111, 3'b111, 3'b111);
        step(1'b0, 3'b111, 3'b111, 3'b111, 3'b111);
        check("rst_owner", {2'b0, owner}, 4'd3);
        check("rst_leds",  {1'b0, leds},  4'd0);

        // single grant to requester 0, then drop req
        step(1'b1, 3'b001, 3'b101, 3'b000, 3'b000);
        check("single_ack",  {1'b0, ack},  4'b0001);
        check("single_leds", {1'b0, leds}, 4'b0101);
        for (int i = 0; i < 8; i++) step(1'b1, 3'b000, 3'b101, 3'b000, 3'b000);
        check("single_keep", {1'b0, leds}, 4'b0101);

        // round-robin with all requests held, from a fresh pointer
        step(1'b0, 3'b000, 3'b000, 3'b000, 3'b000);
        for (int i = 0; i < 21; i++) step(1'b1, 3'b111, 3'b001, 3'b010, 3'b100);

        // reset in the middle of HOLD, then regrant requester 1
        step(1'b0, 3'b000, 3'b000, 3'b000, 3'b000);
        step(1'b1, 3'b010, 3'b000, 3'b110, 3'b000);
        step(1'b1, 3'b000, 3'b000, 3'b110, 3'b000);
        step(1'b1, 3'b000, 3'b000, 3'b110, 3'b000);
        step(1'b0, 3'b010, 3'b000, 3'b110, 3'b000);
        check("midhold_busy", {3'b0, busy}, 4'd0);
        step(1'b0, 3'b010, 3'b000, 3'b110, 3'b000);
        step(1'b1, 3'b010, 3'b000, 3'b110, 3'b000);
        check("regrant_ack", {1'b0, ack}, 4'b0010);
        for (int i = 0; i < 6; i++) step(1'b1, 3'b000, 3'b000, 3'b110, 3'b000);

        // req[0] raised during HOLD after a grant to 2
        step(1'b0, 3'b000, 3'b000, 3'b000, 3'b000);
        step(1'b1, 3'b100, 3'b011, 3'b000, 3'b111);
        first_ack_cyc = cyc;
        second_ack_cyc = -1;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 3'b001, 3'b011, 3'b000, 3'b111);
            if (ack == 3'b001 && second_ack_cyc < 0) second_ack_cyc = cyc;
        end
        check("hold_spacing", 4'(second_ack_cyc - first_ack_cyc), 4'd5);

        // random phase
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 39) != 0), 3'($urandom), 3'($urandom),
                 3'($urandom), 3'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
